// File: rtl/riscv_mem_port_arbiter.sv
// rtl/riscv_mem_port_arbiter.sv - imem/dmem to shared memory port arbiter with in-order response steering (optional perf counters: RISCV_MEM_ARB_PERF_EN)
module riscv_mem_port_arbiter #(
  parameter int REQ_SZ    = 67,
  parameter int RESP_SZ   = 35,
  parameter int MAX_OUTST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REQ_SZ-1:0]  imemreq_msg,
  input  logic               imemreq_val,
  output logic               imemreq_rdy,
  output logic [RESP_SZ-1:0] imemresp_msg,
  output logic               imemresp_val,
  input  logic [REQ_SZ-1:0]  dmemreq_msg,
  input  logic               dmemreq_val,
  output logic               dmemreq_rdy,
  output logic [RESP_SZ-1:0] dmemresp_msg,
  output logic               dmemresp_val,
  output logic [REQ_SZ-1:0]  memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [RESP_SZ-1:0] memresp_msg,
  input  logic               memresp_val,
  output logic               resp_err,
  output logic [31:0]        perf_imem_grants,
  output logic [31:0]        perf_dmem_grants,
  output logic [31:0]        perf_conflicts
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTST);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic {
    PORT_IMEM = 1'b0,
    PORT_DMEM = 1'b1
  } port_e;

  // ID queue: one bit per outstanding request, 1 means the request came from dmem
  logic [MAX_OUTST-1:0] r_idq;
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  port_e                r_last_grant;
  logic                 r_resp_err;

  port_e                w_grant;
  logic                 w_run;
  logic                 w_space;
  logic                 w_fire;
  logic                 w_pop;
  logic                 w_spurious;
  logic                 w_head_dmem;

  // Grant selection: a lone requester wins outright, a conflict alternates against the last accepted port
  always_comb begin
    w_grant = PORT_IMEM;
    if (imemreq_val && dmemreq_val) begin
      w_grant = (r_last_grant == PORT_DMEM) ? PORT_IMEM : PORT_DMEM;
    end else if (dmemreq_val) begin
      w_grant = PORT_DMEM;
    end
  end

  assign w_run       = reset;
  assign w_space     = (r_count != CNT_FULL);
  assign memreq_val  = w_run & w_space & (imemreq_val | dmemreq_val);
  assign memreq_msg  = (w_grant == PORT_DMEM) ? dmemreq_msg : imemreq_msg;
  assign imemreq_rdy = w_run & w_space & memreq_rdy & (w_grant == PORT_IMEM);
  assign dmemreq_rdy = w_run & w_space & memreq_rdy & (w_grant == PORT_DMEM);
  assign w_fire      = memreq_val & memreq_rdy;

  // A response is only routed when something is outstanding; otherwise it is dropped and flagged
  assign w_pop        = w_run & memresp_val & (r_count != '0);
  assign w_spurious   = w_run & memresp_val & (r_count == '0);
  assign w_head_dmem  = r_idq[r_head];
  assign imemresp_val = w_pop & ~w_head_dmem;
  assign dmemresp_val = w_pop & w_head_dmem;
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign resp_err     = r_resp_err;

  // ID storage needs no reset: entries are only read once count says they were written
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_idq[r_tail] <= (w_grant == PORT_DMEM);
    end
  end

  // Queue pointers, occupancy, round-robin history and sticky error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_last_grant <= PORT_DMEM;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_fire) begin
        r_tail       <= r_tail + PTR_ONE;
        r_last_grant <= w_grant;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      if (w_fire && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_fire && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end
      if (w_spurious) begin
        r_resp_err <= 1'b1;
      end
    end
  end

`ifdef RISCV_MEM_ARB_PERF_EN
  logic [31:0] r_perf_imem;
  logic [31:0] r_perf_dmem;
  logic [31:0] r_perf_conf;

  // Event counters: accepted grants per port and cycles where both ports contended with room available
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_imem <= '0;
      r_perf_dmem <= '0;
      r_perf_conf <= '0;
    end else begin
      if (w_fire && (w_grant == PORT_IMEM)) begin
        r_perf_imem <= r_perf_imem + 32'd1;
      end
      if (w_fire && (w_grant == PORT_DMEM)) begin
        r_perf_dmem <= r_perf_dmem + 32'd1;
      end
      if (imemreq_val && dmemreq_val && w_space) begin
        r_perf_conf <= r_perf_conf + 32'd1;
      end
    end
  end

  assign perf_imem_grants = r_perf_imem;
  assign perf_dmem_grants = r_perf_dmem;
  assign perf_conflicts   = r_perf_conf;
`else
  assign perf_imem_grants = 32'd0;
  assign perf_dmem_grants = 32'd0;
  assign perf_conflicts   = 32'd0;
`endif

endmodule
